// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 receive types and frame constants
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam int   PS2_DATA_BITS = 8;
  localparam logic START_BIT     = 1'b0;
  localparam logic STOP_BIT      = 1'b1;

  // Odd parity holds when data bits plus parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// rtl/ps2_sync_filter.sv - 2-FF synchronizer plus run-length glitch filter for one PS/2 line
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic line_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          filt_q;
  logic [CW-1:0] cnt_q;

  // The counter tracks how many consecutive samples disagree with the filtered value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      if (sync2_q == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_q <= sync2_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign line_o = filt_q;

endmodule

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host deframer with valid/ready byte delivery and error pulses
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic clk_f, dat_f, clk_f_q, fall;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .rst_n(rst_n), .line_i(ps2_clk_in), .line_o(clk_f)
  );
  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk(clk), .rst_n(rst_n), .line_i(ps2_dat_in), .line_o(dat_f)
  );

  ps2_state_e              state_q, state_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
  logic                    par_q, par_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [7:0]              rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;

  assign fall = clk_f_q & ~clk_f;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;
    tmo_d      = (state_q == IDLE || fall) ? '0 : tmo_q + TW'(1);

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (fall) begin
      case (state_q)
        IDLE: begin
          if (dat_f == START_BIT) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {dat_f, shift_q[PS2_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_f;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          // A bad stop bit masks any parity failure in the same frame.
          if (dat_f != STOP_BIT) begin
            ferr_d = 1'b1;
          end else if (!odd_parity_ok(shift_q, par_q)) begin
            perr_d = 1'b1;
          end else if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      ferr_d  = 1'b1;
      state_d = IDLE;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_f_q    <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      clk_f_q    <= clk_f;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - randomized self-checking bench for ps2_rx against a frame-level model
module tb_ps2_rx;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int HALF           = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk_in = 1'b1;
  logic       ps2_dat_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       parity_err, frame_err, overrun;

  ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int n_perr, n_ferr, n_ovr, n_vcyc, rise_cyc, stop_cyc;
  logic prev_valid = 1'b0;
  logic [7:0] got[$];
  event stop_ev;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      n_perr += int'(parity_err);
      n_ferr += int'(frame_err);
      n_ovr  += int'(overrun);
      n_vcyc += int'(rx_valid);
      if (rx_valid && !prev_valid) rise_cyc = cyc;
      if (rx_valid && rx_ready) got.push_back(rx_data);
    end
    prev_valid = rx_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_perr = 0; n_ferr = 0; n_ovr = 0; n_vcyc = 0; rise_cyc = -1;
    got.delete();
  endtask

  // Device-side frame generator: data changes while the clock is high, the host samples on the fall.
  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat_in = bits[i];
      tick(HALF);
      ps2_clk_in = 1'b0;
      if (i == 10) begin
        stop_cyc = cyc;
        -> stop_ev;
      end
      tick(HALF);
      ps2_clk_in = 1'b1;
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad_par, input bit stop_v);
    logic par;
    par = ~(^d) ^ bad_par;
    return {stop_v, par, d, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop_v);
    send_bits(make_frame(d, bad_par, stop_v), 11);
    ps2_dat_in = 1'b1;
    tick(2 * HALF);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    n_chk++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); else n_pass++;
    n_chk++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_data); else n_pass++;
    n_chk++; if ({parity_err, frame_err, overrun} !== 3'b000)
      $display("FAIL reset_pulses: got %b expected 000", {parity_err, frame_err, overrun}); else n_pass++;
  endtask

  task automatic test_good();
    rx_ready = 1'b1;
    clear_counts();
    send_frame(8'h1C, 0, 1);
    n_chk++; if (got.size() != 1 || got[0] !== 8'h1C)
      $display("FAIL good_byte: got %0d bytes first %h expected 1 byte 1c", got.size(), got.size() ? got[0] : 8'hxx); else n_pass++;
    n_chk++; if (n_vcyc != 1) $display("FAIL good_valid_cycles: got %0d expected 1", n_vcyc); else n_pass++;
    n_chk++; if (n_perr + n_ferr + n_ovr != 0)
      $display("FAIL good_errors: got %0d/%0d/%0d expected 0/0/0", n_perr, n_ferr, n_ovr); else n_pass++;
  endtask

  task automatic test_parity();
    rx_ready = 1'b1;
    clear_counts();
    send_frame(8'h1C, 1, 1);
    n_chk++; if (n_perr != 1) $display("FAIL parity_pulse: got %0d expected 1", n_perr); else n_pass++;
    n_chk++; if (n_vcyc != 0 || n_ferr != 0)
      $display("FAIL parity_discard: got valid=%0d ferr=%0d expected 0/0", n_vcyc, n_ferr); else n_pass++;
    send_frame(8'h1C, 0, 1);
    n_chk++; if (got.size() != 1 || got[0] !== 8'h1C)
      $display("FAIL parity_recover: got %0d bytes expected 1c", got.size()); else n_pass++;
  endtask

  task automatic test_overrun();
    rx_ready = 1'b0;
    clear_counts();
    send_frame(8'hF0, 0, 1);
    send_frame(8'h1C, 0, 1);
    n_chk++; if (rx_data !== 8'hF0 || rx_valid !== 1'b1)
      $display("FAIL overrun_hold: got %h/%b expected f0/1", rx_data, rx_valid); else n_pass++;
    n_chk++; if (n_ovr != 1) $display("FAIL overrun_pulse: got %0d expected 1", n_ovr); else n_pass++;
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(1);
    n_chk++; if (rx_valid !== 1'b0) $display("FAIL overrun_drain: got %b expected 0", rx_valid); else n_pass++;
    n_chk++; if (got.size() != 1 || got[0] !== 8'hF0)
      $display("FAIL overrun_consumed: got %0d bytes expected f0", got.size()); else n_pass++;
  endtask

  task automatic test_timeout();
    rx_ready = 1'b1;
    clear_counts();
    send_bits(make_frame(8'h07, 0, 1), 4);
    ps2_dat_in = 1'b1;
    tick(TIMEOUT_CYCLES - 100);
    n_chk++; if (n_ferr != 0) $display("FAIL timeout_early: got %0d expected 0", n_ferr); else n_pass++;
    tick(300);
    n_chk++; if (n_ferr != 1) $display("FAIL timeout_pulse: got %0d expected 1", n_ferr); else n_pass++;
    send_frame(8'h5A, 0, 1);
    n_chk++; if (got.size() != 1 || got[0] !== 8'h5A || n_ferr != 1)
      $display("FAIL timeout_recover: got %0d bytes ferr=%0d expected 5a ferr=1", got.size(), n_ferr); else n_pass++;
  endtask

  task automatic test_stop0();
    rx_ready = 1'b1;
    clear_counts();
    send_frame(8'h1C, 0, 0);
    n_chk++; if (n_ferr != 1 || n_perr != 0 || n_vcyc != 0)
      $display("FAIL stop0: got ferr=%0d perr=%0d valid=%0d expected 1/0/0", n_ferr, n_perr, n_vcyc); else n_pass++;
  endtask

  task automatic test_glitch();
    rx_ready = 1'b1;
    clear_counts();
    ps2_dat_in = 1'b0;
    tick(20);
    ps2_clk_in = 1'b0;
    tick(3);
    ps2_clk_in = 1'b1;
    tick(20);
    ps2_dat_in = 1'b1;
    tick(40);
    send_frame(8'h1C, 0, 1);
    n_chk++; if (got.size() != 1 || got[0] !== 8'h1C || n_perr + n_ferr != 0)
      $display("FAIL glitch: got %0d bytes perr=%0d ferr=%0d expected 1c 0/0", got.size(), n_perr, n_ferr); else n_pass++;
  endtask

  task automatic test_reset_mid();
    rx_ready = 1'b0;
    clear_counts();
    send_frame(8'h33, 0, 1);
    send_bits(make_frame(8'h15, 0, 1), 6);
    rst_n = 1'b0;
    tick(2);
    n_chk++; if ({rx_valid, rx_data, parity_err, frame_err, overrun} !== 12'h000)
      $display("FAIL reset_mid_outputs: got %b_%h_%b expected 0_00_000", rx_valid, rx_data, {parity_err, frame_err, overrun}); else n_pass++;
    ps2_dat_in = 1'b1;
    ps2_clk_in = 1'b1;
    rst_n = 1'b1;
    tick(20);
    clear_counts();
    rx_ready = 1'b1;
    send_frame(8'h29, 0, 1);
    n_chk++; if (got.size() != 1 || got[0] !== 8'h29 || n_perr + n_ferr + n_ovr != 0)
      $display("FAIL reset_mid_recover: got %0d bytes errs=%0d expected 29 0", got.size(), n_perr + n_ferr + n_ovr); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat;
    rx_ready = 1'b0;
    clear_counts();
    send_frame(8'h11, 0, 1);
    lat = rise_cyc - stop_cyc;
    n_chk++; if (rise_cyc < 0 || lat < FILTER_LEN + 2 || lat > FILTER_LEN + 5)
      $display("FAIL latency: got %0d expected %0d..%0d", lat, FILTER_LEN + 2, FILTER_LEN + 5); else n_pass++;
    if (rise_cyc < 0) lat = FILTER_LEN + 3;
    fork
      send_frame(8'h22, 0, 1);
      begin
        @(stop_ev);
        tick(lat - 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    n_chk++; if (rx_valid !== 1'b1 || rx_data !== 8'h22 || n_ovr != 0)
      $display("FAIL simul_load: got %b/%h ovr=%0d expected 1/22 ovr=0", rx_valid, rx_data, n_ovr); else n_pass++;
    n_chk++; if (got.size() != 1 || got[0] !== 8'h11)
      $display("FAIL simul_consume: got %0d bytes expected 11", got.size()); else n_pass++;
    rx_ready = 1'b1;
    tick(2);
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int exp_perr = 0, exp_ferr = 0;
    rx_ready = 1'b1;
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      logic [7:0] d;
      int kind;
      d = 8'($urandom);
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        exp_perr++;
        send_frame(d, 1, 1);
      end else if (kind == 1) begin
        exp_ferr++;
        send_frame(d, $urandom_range(0, 1), 0);
      end else begin
        exp_q.push_back(d);
        send_frame(d, 0, 1);
      end
    end
    n_chk++; if (n_perr != exp_perr || n_ferr != exp_ferr || n_ovr != 0)
      $display("FAIL random_errors: got %0d/%0d/%0d expected %0d/%0d/0", n_perr, n_ferr, n_ovr, exp_perr, exp_ferr); else n_pass++;
    n_chk++; if (got.size() != exp_q.size() || n_vcyc != exp_q.size())
      $display("FAIL random_count: got %0d bytes %0d valid cycles expected %0d", got.size(), n_vcyc, exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_chk++; if (got[i] !== exp_q[i]) $display("FAIL random_byte%0d: got %h expected %h", i, got[i], exp_q[i]); else n_pass++;
    end
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_good();
    test_parity();
    test_overrun();
    test_timeout();
    test_stop0();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
